// File: rtl/pru_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pru_cmd_pkg: command layout and bus-word packing for pru_cmd_issuer |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pru_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_DRAW  = 2'b00,
    CMD_COLOR = 2'b01,
    CMD_RSV2  = 2'b10,
    CMD_RSV3  = 2'b11
  } cmd_type_e;

  localparam logic [1:0] TAG_W0  = 2'b01;
  localparam logic [1:0] TAG_W1  = 2'b10;
  localparam logic [1:0] TAG_CLR = 2'b11;

  typedef struct packed {
    cmd_type_e   cmd_type;
    logic [1:0]  shape;
    logic [1:0]  color;
    logic        subtract;
    logic [9:0]  row;
    logic [8:0]  col;
    logic [9:0]  width;
    logic [8:0]  height_radius;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic [31:0] pack_w0(input cmd_t c);
    if (c.cmd_type == CMD_COLOR)
      return {TAG_CLR, 28'b0, c.color};
    return {TAG_W0, c.shape, c.color, c.subtract, c.row, c.col, 6'b0};
  endfunction

  function automatic logic [31:0] pack_w1(input cmd_t c);
    return {TAG_W1, c.width, c.height_radius, 11'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pru_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pru_cmd_fifo: synchronous FIFO with registered full/empty flags     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pru_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 45
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one = 1;
  localparam logic [c_aw:0]   c_cnt_one = 1;
  localparam logic [c_aw:0]   c_cnt_full = DEPTH[c_aw:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [c_aw:0]    w_count_nxt;

  assign w_push = push && !r_full;
  assign w_pop  = pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + c_cnt_one;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - c_cnt_one;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_cnt_full);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/pru_cmd_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pru_cmd_issuer: queues draw/colour commands and issues them as     |
// | acknowledged 32-bit writes to the PRU command buffer. Rev 1.0      |
// +--------------------------------------------------------------------+
module pru_cmd_issuer
  import pru_cmd_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
  parameter int          ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_type_i,
  input  logic [1:0]  shape_i,
  input  logic [1:0]  color_i,
  input  logic        subtract_i,
  input  logic [9:0]  row_i,
  input  logic [8:0]  col_i,
  input  logic [9:0]  width_i,
  input  logic [8:0]  height_radius_i,
  output logic [31:0] b_addr_o,
  output logic [31:0] b_data_o,
  output logic        b_write_o,
  input  logic        b_ack_i,
  output logic        idle_o,
  output logic        err_o,
  output logic [15:0] sent_o
);

  localparam int c_tw = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_tmo_last = c_tw'(ACK_TIMEOUT - 1);
  localparam logic [c_tw-1:0] c_tmo_one  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND0 = 2'd1,
    ST_SEND1 = 2'd2
  } state_e;

  state_e          r_state;
  cmd_t            r_cmd;
  logic [31:0]     r_addr;
  logic [31:0]     r_data;
  logic            r_write;
  logic            r_err;
  logic [15:0]     r_sent;
  logic [c_tw-1:0] r_tmo;

  cmd_t w_cmd_in;
  cmd_t w_head;
  logic w_full;
  logic w_empty;
  logic w_rsvd;
  logic w_accept;
  logic w_push;
  logic w_pop;

  assign w_cmd_in = '{cmd_type: cmd_type_e'(cmd_type_i), shape: shape_i, color: color_i,
                      subtract: subtract_i, row: row_i, col: col_i, width: width_i,
                      height_radius: height_radius_i};

  // Reserved types are handshaken away so the producer never stalls on them.
  assign w_rsvd   = cmd_type_i[1];
  assign w_accept = cmd_valid_i && !w_full;
  assign w_push   = w_accept && !w_rsvd;
  assign w_pop    = (r_state == ST_IDLE) && !w_empty;

  pru_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_cmd_in),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_sent  <= '0;
      r_tmo   <= '0;
    end else begin
      if (w_accept && w_rsvd)
        r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cmd   <= w_head;
            r_data  <= pack_w0(w_head);
            r_addr  <= BASE_ADDR;
            r_write <= 1'b1;
            r_tmo   <= '0;
            r_state <= ST_SEND0;
          end
        end
        ST_SEND0: begin
          if (b_ack_i) begin
            if (r_cmd.cmd_type == CMD_DRAW) begin
              r_data  <= pack_w1(r_cmd);
              r_tmo   <= '0;
              r_state <= ST_SEND1;
            end else begin
              r_write <= 1'b0;
              r_sent  <= r_sent + 16'd1;
              r_state <= ST_IDLE;
            end
          end else if (r_tmo == c_tmo_last) begin
            r_write <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + c_tmo_one;
          end
        end
        ST_SEND1: begin
          if (b_ack_i) begin
            r_write <= 1'b0;
            r_sent  <= r_sent + 16'd1;
            r_state <= ST_IDLE;
          end else if (r_tmo == c_tmo_last) begin
            r_write <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + c_tmo_one;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = !w_full;
  assign b_addr_o    = r_addr;
  assign b_data_o    = r_data;
  assign b_write_o   = r_write;
  assign err_o       = r_err;
  assign sent_o      = r_sent;
  assign idle_o      = w_empty && (r_state == ST_IDLE);

endmodule
`default_nettype wire
